// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Purpose
//   Byte FIFO sitting in front of a UART transmitter. Bytes written by the
//   host are queued in a DEPTH x 8 circular buffer and handed to the
//   transmitter one at a time through a single-cycle launch strobe. After each
//   launch the block waits for the transmitter to raise tx_busy and then drop
//   it again before launching the next byte. If tx_busy never rises within
//   BUSY_TIMEOUT cycles the byte is considered lost and the next one is
//   launched (no retry).
//
// Parameters
//   DEPTH         FIFO entries; power of two, >= 2 (default 16)
//   BUSY_TIMEOUT  cycles to wait for tx_busy after a launch; 1..15 (default 4)
//
// Ports
//   clk         in   1               clock, all state on the rising edge
//   rstn        in   1               asynchronous active-low reset
//   wr_data     in   8               byte to enqueue
//   wr_en       in   1               enqueue request, sampled each rising edge
//   full        out  1               FIFO holds DEPTH entries
//   empty       out  1               FIFO holds no entries
//   level       out  $clog2(DEPTH)+1 current entry count
//   tx_data     out  8               byte presented to the transmitter
//   tx_valid    out  1               one-cycle launch strobe
//   tx_busy     in   1               transmitter busy
//
// Optional feature (macro UART_TX_FIFO_OVF_EN)
//   ovf_clr     in   1               clears overflow and drop_count
//   overflow    out  1               sticky: a write was dropped while full
//   drop_count  out  8               number of dropped writes, saturating
//   Without the macro these ports do not exist and dropped writes are silent.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [7:0]                 wr_data,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    input  logic                       ovf_clr,
    output logic                       overflow,
    output logic [7:0]                 drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = 4;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LIMIT  = TW'(BUSY_TIMEOUT);

    // Launch FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [1:0]    state_q,  state_d;
    logic [TW-1:0] tmo_q,    tmo_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;

    logic          full_w;
    logic          wr_accept;
    logic          pop;
    logic [TW-1:0] tmo_inc;

    // -------------------------------------------------------------------------
    // Status flags come straight from the registered count so that wr_en and
    // tx_busy never reach them combinationally.
    // -------------------------------------------------------------------------
    assign full_w = (count_q == COUNT_FULL);
    assign full   = full_w;
    assign empty  = (count_q == '0);
    assign level  = count_q;

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

    // A write is judged against the registered full flag only; a pop in the
    // same cycle does not make room for it.
    assign wr_accept = wr_en & ~full_w;

    // Pop only from IDLE and only while the transmitter is idle, so a strobe
    // can never follow an edge at which tx_busy was high.
    assign pop = (state_q == ST_IDLE) && (count_q != '0) && !tx_busy;

    assign tmo_inc = tmo_q + TW'(1);

    // -------------------------------------------------------------------------
    // Pointer and count update
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // DEPTH is a power of two, so natural AW-bit overflow gives the wrap.
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Launch FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_valid_d = 1'b1;
                    state_d    = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                // Strobe lasts exactly the one cycle spent in LAUNCH.
                tx_valid_d = 1'b0;
                tmo_d      = '0;
                state_d    = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    tmo_d = tmo_inc;
                    // Transmitter never acknowledged: give the byte up.
                    if (tmo_inc == TMO_LIMIT) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers with asynchronous reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Buffer storage carries no reset; stale contents are unreachable once
    // the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // -------------------------------------------------------------------------
    // Overflow reporting
    // -------------------------------------------------------------------------
    logic       overflow_q,   overflow_d;
    logic [7:0] drop_count_q, drop_count_d;
    logic       drop;

    assign drop = wr_en & full_w;

    // Clear takes priority over a drop in the same cycle.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (ovf_clr) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'h00;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q   <= 1'b0;
            drop_count_q <= 8'h00;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. A queue-based reference model predicts the
// FIFO contents and launch strobes; a compare process checks the DUT against
// it on every falling edge. A serial transmitter model (4 clocks per bit) and
// a line receiver are used for the end-to-end ordering test. Define
// UART_TX_FIFO_OVF_EN for both files to exercise the overflow ports.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 4;
    localparam int LW           = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en = 1'b0;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_busy;

    logic          busy_drv = 1'b0;
    logic          use_ser  = 1'b0;
    logic          ser_busy = 1'b0;

    assign tx_busy = use_ser ? ser_busy : busy_drv;

`ifdef UART_TX_FIFO_OVF_EN
    logic          ovf_clr = 1'b0;
    logic          overflow;
    logic [7:0]    drop_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH(DEPTH),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .full(full),
        .empty(empty),
        .level(level),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_busy(tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf_clr(ovf_clr),
        .overflow(overflow),
        .drop_count(drop_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: a byte queue plus the launch pacing rules.
    //   - a byte is launched when the transmitter is ready for one, the queue
    //     holds something and tx_busy is low;
    //   - the edge after a launch only acknowledges it;
    //   - then the block waits until tx_busy has risen and fallen again, or
    //     until BUSY_TIMEOUT quiet edges have passed without tx_busy.
    // -------------------------------------------------------------------------
    logic [7:0] mq[$];
    logic       m_valid;
    logic [7:0] m_data;
    bit         m_ready;
    bit         m_ack;
    bit         m_waiting;
    bit         m_seen_busy;
    int         m_quiet;
    bit         m_busy_prev;
    bit         m_pop;
    bit         m_push;
    int         m_n;
    bit         m_ovf;
    logic [7:0] m_drop;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            m_valid     = 1'b0;
            m_data      = 8'h00;
            m_ready     = 1'b1;
            m_ack       = 1'b0;
            m_waiting   = 1'b0;
            m_seen_busy = 1'b0;
            m_quiet     = 0;
            m_busy_prev = 1'b0;
            m_ovf       = 1'b0;
            m_drop      = 8'h00;
        end else begin
            m_n         = mq.size();
            m_busy_prev = tx_busy;
            m_pop       = m_ready && (m_n > 0) && !tx_busy;
            m_push      = wr_en && (m_n < DEPTH);

`ifdef UART_TX_FIFO_OVF_EN
            if (ovf_clr) begin
                m_ovf  = 1'b0;
                m_drop = 8'h00;
            end else if (wr_en && m_n == DEPTH) begin
                m_ovf = 1'b1;
                if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            end
`endif

            m_valid = 1'b0;
            if (m_ack) begin
                m_ack       = 1'b0;
                m_waiting   = 1'b1;
                m_seen_busy = 1'b0;
                m_quiet     = 0;
            end else if (m_waiting) begin
                if (m_seen_busy) begin
                    if (!tx_busy) begin
                        m_waiting = 1'b0;
                        m_ready   = 1'b1;
                    end
                end else if (tx_busy) begin
                    m_seen_busy = 1'b1;
                end else begin
                    m_quiet++;
                    if (m_quiet == BUSY_TIMEOUT) begin
                        m_waiting = 1'b0;
                        m_ready   = 1'b1;
                    end
                end
            end

            if (m_pop) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
                m_ready = 1'b0;
                m_ack   = 1'b1;
            end
            if (m_push) mq.push_back(wr_data);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("tx_valid", tx_valid, m_valid);
        chk("tx_data", tx_data, m_data);
        chk("level", level, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        chk("valid_after_busy", tx_valid & m_busy_prev, 0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drop);
`endif
    end

    // -------------------------------------------------------------------------
    // Serial transmitter model: 10-bit frame, 4 clocks per bit, busy from the
    // edge after it latches tx_data until the stop bit ends.
    // -------------------------------------------------------------------------
    logic [9:0] ser_sh = 10'h3FF;
    int         ser_cnt = 0;
    logic       txd = 1'b1;

    always @(posedge clk) begin
        if (use_ser) begin
            if (!ser_busy) begin
                if (tx_valid) begin
                    ser_sh   <= {1'b1, tx_data, 1'b0};
                    ser_busy <= 1'b1;
                    ser_cnt  <= 0;
                    txd      <= 1'b0;
                end
            end else if (ser_cnt == 39) begin
                ser_busy <= 1'b0;
                txd      <= 1'b1;
            end else begin
                ser_cnt <= ser_cnt + 1;
                txd     <= ser_sh[(ser_cnt + 1) / 4];
            end
        end
    end

    // Line receiver: samples each bit one edge into its 4-clock window.
    logic [7:0] rx_q[$];
    int         rx_p = -1;
    logic [9:0] rx_sh = '0;

    always @(posedge clk) begin
        if (rx_p < 0) begin
            if (!txd) rx_p = 0;
        end else begin
            rx_p = rx_p + 1;
            if ((rx_p % 4) == 1) rx_sh[rx_p / 4] = txd;
            if (rx_p == 37) begin
                chk("rx_start_bit", rx_sh[0], 0);
                chk("rx_stop_bit", rx_sh[9], 1);
                rx_q.push_back(rx_sh[8:1]);
                rx_p = -1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    logic [7:0] got[$];
    int         waited;

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset release values
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);

        // Single byte: strobe one edge after the write edge, one cycle long
        busy_drv = 1'b0;
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        chk("a5_level_after_write", level, 1);
        chk("a5_valid_early", tx_valid, 0);
        @(negedge clk);
        chk("a5_valid", tx_valid, 1);
        chk("a5_data", tx_data, 8'hA5);
        chk("a5_level_after_pop", level, 0);
        @(negedge clk);
        chk("a5_valid_one_cycle", tx_valid, 0);
        chk("a5_data_held", tx_data, 8'hA5);
        repeat (8) @(negedge clk);

        // Fill while transmitter busy; 17th write is dropped
        busy_drv = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
            if (i == 15) begin
                chk("fill_full16", full, 1);
                chk("fill_level16", level, 16);
            end
        end
        wr_en = 1'b0;
        chk("fill_full17", full, 1);
        chk("fill_level17", level, 16);
`ifdef UART_TX_FIFO_OVF_EN
        chk("ovf_set", overflow, 1);
        chk("ovf_drop1", drop_count, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        chk("ovf_drop_cleared", drop_count, 0);
`endif

        // Drain with tx_busy low: each launch times out, order preserved
        busy_drv = 1'b0;
        got.delete();
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            if (tx_valid) got.push_back(tx_data);
        end
        chk("drain_count", got.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < got.size()) chk("drain_order", got[i], i);
        end
        chk("drain_empty", empty, 1);

        // Two bytes with tx_busy tied low: second launch six edges later
        wr_en = 1'b1; wr_data = 8'h11;
        @(negedge clk);
        wr_data = 8'h22;
        @(negedge clk);
        wr_en = 1'b0;
        chk("to_first_valid", tx_valid, 1);
        chk("to_first_data", tx_data, 8'h11);
        chk("to_level_simul", level, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("to_gap_no_valid", tx_valid, 0);
        end
        @(negedge clk);
        chk("to_second_valid", tx_valid, 1);
        chk("to_second_data", tx_data, 8'h22);
        repeat (10) @(negedge clk);

        // End-to-end through the serial transmitter model
        use_ser = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        waited = 0;
        while (rx_q.size() < 4 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("ser_timeout", (waited >= 400), 0);
        chk("ser_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size()) chk("ser_byte", rx_q[i], i + 1);
        end
        repeat (6) @(negedge clk);
        use_ser = 1'b0;
        busy_drv = 1'b0;
        repeat (4) @(negedge clk);

        // Asynchronous reset during a launch with five bytes still queued
        busy_drv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("rst_mid_level6", level, 6);
        busy_drv = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_valid_before", tx_valid, 1);
        chk("rst_mid_level5", level, 5);
        rstn = 1'b0;
        #1;
        chk("rst_mid_valid", tx_valid, 0);
        chk("rst_mid_level", level, 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_data", tx_data, 8'h00);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_rst_no_launch", tx_valid, 0);
        end
        chk("post_rst_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, >=2.
REQ-002 Parameter BUSY_TIMEOUT, default 4, max cycles to wait for tx_busy rise after launch; range 1..15.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 wr_en  input  1  enqueue request, sampled each rising edge.
REQ-007 full  output  1  count==DEPTH.
REQ-008 empty  output  1  count==0.
REQ-009 level  output  $clog2(DEPTH)+1  current entry count.
REQ-010 tx_data  output  8  byte presented to downstream transmitter.
REQ-011 tx_valid  output  1  one-cycle launch strobe to transmitter.
REQ-012 tx_busy  input  1  transmitter busy; high from the cycle after it latches tx_data until its stop bit ends.

Function
REQ-013 Storage: DEPTH x 8 circular buffer; rd_ptr/wr_ptr wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
REQ-014 Write: wr_en high and full low at an edge -> store wr_data at wr_ptr, increment wr_ptr.
REQ-015 Write while full (registered full, same-cycle pop not considered) SHALL be dropped; contents, pointers, count unchanged.
REQ-016 full, empty and level are derived from registered count only; no combinational path from wr_en or tx_busy.
REQ-017 Launch FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE: count!=0 and tx_busy low -> tx_data<=mem[rd_ptr], tx_valid<=1, rd_ptr++, count decremented (pop), go LAUNCH; otherwise stay.
REQ-019 LAUNCH: tx_valid<=0, clear timeout counter, go WAIT_BUSY; tx_valid is therefore high for exactly one cycle.
REQ-020 WAIT_BUSY: tx_busy high -> WAIT_DONE; otherwise increment timeout counter; counter reaching BUSY_TIMEOUT -> IDLE (byte considered lost, no retry).
REQ-021 WAIT_DONE: tx_busy low -> IDLE.
REQ-022 tx_data holds last launched byte until next launch.
REQ-023 tx_valid SHALL never be asserted while tx_busy is high at the preceding edge.
REQ-024 Simultaneous accepted write and pop: both occur, count unchanged.
REQ-025 Write to empty FIFO: earliest tx_valid is the cycle after the write edge (1-cycle latency).
REQ-026 Bytes leave in write order; no reordering, no duplication.

Reset
REQ-027 rstn low SHALL immediately force: rd_ptr=0, wr_ptr=0, count=0, state IDLE, tx_valid=0, tx_data=8'h00, empty=1, full=0, level=0, timeout counter 0.
REQ-028 Reset mid-operation discards all stored bytes; a strobe in progress is cut off asynchronously.
REQ-029 Buffer memory contents need not be reset.

Configuration
REQ-030 Macro UART_TX_FIFO_OVF_EN defined: adds ports ovf_clr input 1, overflow output 1, drop_count output 8.
REQ-031 With macro: each dropped write (REQ-015) sets overflow (sticky) and increments drop_count, saturating at 8'hFF; ovf_clr high clears both, and clear wins over a same-cycle drop; both reset to 0.
REQ-032 Without macro: those ports and logic are absent; drops are silent; all other behaviour identical.

Verification
REQ-033 Reset release -> empty=1, full=0, level=0, tx_valid=0, tx_data=8'h00.
REQ-034 tx_busy low, write 8'hA5 once -> tx_valid high exactly one cycle, starting the cycle after the write edge, with tx_data=8'hA5; level returns to 0.
REQ-035 Hold tx_busy high, write 17 bytes 8'h00..8'h10 -> full=1, level=16 after 16th write, 17th dropped; with macro overflow=1, drop_count=1; ovf_clr pulse -> both 0.
REQ-036 Connect serial transmitter model (4 clocks/bit), write 8'h01,8'h02,8'h03,8'h04 back-to-back -> serial line carries them in order; no tx_valid while tx_busy high.
REQ-037 tx_busy tied low, write 8'h11,8'h22 -> 8'h11 launched, FSM returns to IDLE after 4 WAIT_BUSY cycles, then 8'h22 launched.
REQ-038 Assert rstn low while level=5 and mid-launch -> tx_valid=0, level=0, empty=1 immediately; no further launches after release.
